// File: rtl/serial_adder.sv
`default_nettype none
//============================================================================
// Module      : serial_adder
// Description : Multi-cycle WIDTH-bit adder with carry-in. Adds DIGIT bits
//               per clock, least-significant digit first, behind a
//               start/busy/done handshake. Results are registered and only
//               updated on the completion edge.
//               Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input
//               (a - b) and a registered signed-overflow output 'ovf'.
// Revision    : 1.0 - initial release
//============================================================================
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Number of digits per operand and the counter that walks them.
    localparam int c_NDIG = WIDTH / DIGIT;
    localparam int c_CW   = (c_NDIG > 1) ? $clog2(c_NDIG) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NDIG - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Reject configurations where the operand does not split into whole digits.
    generate
        if ((WIDTH < 2) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
            $error("serial_adder: WIDTH must be >= 2 and an exact multiple of DIGIT");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_psum;
    logic             r_carry;
    logic [c_CW-1:0]  r_cnt;

    logic             w_capture;
    logic             w_last;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;
    logic [DIGIT:0]   w_dsum;
    logic [WIDTH+DIGIT-1:0] w_psum_cat;
    logic [WIDTH-1:0] w_next_psum;

    // New operands are accepted whenever no addition is in flight.
    assign w_capture = start && (r_state != c_ST_BUSY);
    assign w_last    = (r_state == c_ST_BUSY) && (r_cnt == c_LAST);

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1; the external carry-in is not used then.
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    // One digit of the sum, with its carry-out in the top bit.
    assign w_dsum = {1'b0, r_a[DIGIT-1:0]}
                  + {1'b0, r_b[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, r_carry};

    // The new digit enters at the top of the partial sum; after the last
    // digit the register holds the complete sum aligned at bit 0.
    assign w_psum_cat  = {w_dsum[DIGIT-1:0], r_psum};
    assign w_next_psum = WIDTH'(w_psum_cat >> DIGIT);

`ifdef SERIAL_ADDER_SUB_EN
    logic w_ovf;
    // Signed overflow: operand sign bits agree but the result sign differs.
    assign w_ovf = (r_a[DIGIT-1] == r_b[DIGIT-1]) && (w_dsum[DIGIT-1] != r_a[DIGIT-1]);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: BUSY runs for exactly c_NDIG cycles.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (start) w_next_state = c_ST_BUSY;
            c_ST_BUSY: if (r_cnt == c_LAST) w_next_state = c_ST_DONE;
            c_ST_DONE: w_next_state = start ? c_ST_BUSY : c_ST_IDLE;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_ST_BUSY: busy = 1'b1;
            c_ST_DONE: done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Operand shift registers, running carry and digit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_psum  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_capture) begin
            r_a     <= a;
            r_b     <= w_b_load;
            r_psum  <= '0;
            r_carry <= w_c_load;
            r_cnt   <= '0;
        end else if (r_state == c_ST_BUSY) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_psum  <= w_next_psum;
            r_carry <= w_dsum[DIGIT];
            r_cnt   <= r_cnt + c_CW'(1);
        end
    end

    // Visible results change only on the edge that finishes the last digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (w_last) begin
            sum  <= w_next_psum;
            cout <= w_dsum[DIGIT];
        end
    end

`ifdef SERIAL_ADDER_SUB_EN
    // Overflow flag registered alongside sum/cout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (w_last) begin
            ovf <= w_ovf;
        end
    end
`endif

endmodule
`default_nettype wire
